// File: rtl/pio_cmd_sequencer.sv
// Command sequencer between Nios PIOs and a 32-bit accumulator datapath.
// A toggle on operation_in[31] launches one opcode; result and status are published back.
module pio_cmd_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [31:0]       operation_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] result_out,
    output logic [7:0]        status_out
);

    typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpLoad = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpMul  = 4'd4;
    localparam logic [3:0] OpAnd  = 4'd5;
    localparam logic [3:0] OpOr   = 4'd6;
    localparam logic [3:0] OpXor  = 4'd7;
    localparam logic [3:0] OpClr  = 4'd8;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic              tog_seen_q, tog_seen_d;
    logic              ack_q, ack_d;
    logic              overrun_q, overrun_d;
    logic              illegal_q, illegal_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic              tog_new;
    logic              ovr_evt;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] prod_next;
    logic              unused_op_bits;

    assign unused_op_bits = ^operation_in[30:4];

    assign tog_new   = operation_in[31] != tog_seen_q;
    assign ovr_evt   = (state_q != StIdle) && tog_new;
    assign sum       = {1'b0, acc_q} + {1'b0, b_q};
    assign prod_next = prod_q + (b_q[0] ? mcand_q : '0);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        b_d        = b_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tog_seen_d = tog_seen_q;
        ack_d      = ack_q;
        overrun_d  = overrun_q;
        illegal_d  = illegal_q;
        carry_d    = carry_q;

        // A toggle while busy is discarded but still absorbed into tog_seen.
        if (ovr_evt) begin
            tog_seen_d = operation_in[31];
        end

        case (state_q)
            StIdle: begin
                if (tog_new) begin
                    op_d       = operation_in[3:0];
                    b_d        = data_in;
                    tog_seen_d = operation_in[31];
                    if (operation_in[3:0] == OpMul) begin
                        state_d = StMul;
                        cnt_d   = '0;
                        mcand_d = acc_q;
                        prod_d  = '0;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                case (op_q)
                    OpNop:  ;
                    OpLoad: acc_d = b_q;
                    OpAdd: begin
                        acc_d   = sum[DATA_W-1:0];
                        carry_d = sum[DATA_W];
                    end
                    OpSub: begin
                        acc_d   = acc_q - b_q;
                        carry_d = acc_q < b_q;
                    end
                    OpAnd:  acc_d = acc_q & b_q;
                    OpOr:   acc_d = acc_q | b_q;
                    OpXor:  acc_d = acc_q ^ b_q;
                    OpClr: begin
                        acc_d     = '0;
                        overrun_d = 1'b0;
                        illegal_d = 1'b0;
                        carry_d   = 1'b0;
                    end
                    default: illegal_d = 1'b1;
                endcase
                state_d = StDone;
            end
            StMul: begin
                // LSB-first shift-add: b_q shifts right, multiplicand shifts left.
                prod_d  = prod_next;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    acc_d   = prod_next;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                ack_d   = tog_seen_d;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (ovr_evt) begin
            overrun_d = 1'b1;
        end

        zero_d = (acc_d == '0);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            b_q        <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            tog_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            overrun_q  <= 1'b0;
            illegal_q  <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tog_seen_q <= tog_seen_d;
            ack_q      <= ack_d;
            overrun_q  <= overrun_d;
            illegal_q  <= illegal_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    assign result_out = acc_q;
    assign status_out = {2'b00, zero_q, carry_q, illegal_q, overrun_q, ack_q,
                         state_q != StIdle};

endmodule
